cic3_row_readout_sched: RTL and testbench

Readout scheduler for one 2x12 CIC3 filter row. On each decimated-sample strobe it snapshots all 24 filter outputs (25 bits each) and drains the enabled channels, lowest index first, onto one shared 25-bit valid/ready readout port. The port feeds the chip's serializer and monitor path. It runs in the filter's high-speed `clk` domain, with the strobe generated alongside `divided_clk`.

---
 rtl/cic3_row_readout_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_cic3_row_readout_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic3_row_readout_sched.sv
// -----------------------------------------------------------------------------
// cic3_row_readout_sched
//
// Readout scheduler for one row of CIC3 decimation filters. Each accepted
// decimated-sample strobe takes a snapshot of every filter output and latches
// the channel mask. The enabled channels are then drained onto a single
// valid/ready port, lowest index first.
//
// Ports
//   clk_i            filter high-speed clock (only clock)
//   reset_i          synchronous, active-high reset
//   enable_i         when 1, sample strobes may be accepted
//   sample_strobe_i  one-cycle pulse per decimated output sample
//   chan_mask_i      1 = channel included in readout
//   filt_out_i       flattened filter outputs, channel i at [i*OUT_WIDTH +: OUT_WIDTH]
//   rd_data_o        snapshot value of the presented channel
//   rd_chan_o        index of the presented channel
//   rd_valid_o       word presented
//   rd_ready_i       consumer accepts the word
//   rd_first_o       presented word is the first of its frame
//   rd_last_o        presented word is the last of its frame
//   rd_frame_o       frame counter stamped on every word, wraps 255 -> 0
//   busy_o           a frame is in progress
//   overrun_o        one-cycle pulse when a strobe is dropped
//   overrun_cnt_o    dropped-strobe count, saturates at 255
//   dbg_state_o      current FSM state (0 = IDLE, 1 = SCAN)
//
// Handshake: a word transfers in any cycle where rd_valid_o and rd_ready_i are
// both 1. rd_valid_o is a register and never looks at rd_ready_i; once it is
// raised it stays high, and rd_data_o/rd_chan_o/rd_first_o/rd_last_o/
// rd_frame_o hold their values until the transfer happens.
// -----------------------------------------------------------------------------
module cic3_row_readout_sched #(
    parameter int NUM_FILTERS = 24,
    parameter int OUT_WIDTH   = 25,
    parameter int CH_WIDTH    = 5
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             enable_i,
    input  logic                             sample_strobe_i,
    input  logic [NUM_FILTERS-1:0]           chan_mask_i,
    input  logic [NUM_FILTERS*OUT_WIDTH-1:0] filt_out_i,
    output logic [OUT_WIDTH-1:0]             rd_data_o,
    output logic [CH_WIDTH-1:0]              rd_chan_o,
    output logic                             rd_valid_o,
    input  logic                             rd_ready_i,
    output logic                             rd_first_o,
    output logic                             rd_last_o,
    output logic [7:0]                       rd_frame_o,
    output logic                             busy_o,
    output logic                             overrun_o,
    output logic [7:0]                       overrun_cnt_o,
    output logic                             dbg_state_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic [CH_WIDTH-1:0]    ptr_q, ptr_d;
    logic [NUM_FILTERS-1:0] mask_q, mask_d;
    logic [7:0]             frame_q, frame_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q, ovr_d;
    logic [7:0]             ovr_cnt_q, ovr_cnt_d;
    logic [OUT_WIDTH-1:0]   snap_q [NUM_FILTERS];

    // -------------------------------------------------------------------------
    // Channel selection
    //   sel_idx   : lowest set bit of mask_q at or above ptr_q
    //   first_idx : lowest set bit of mask_q
    //   last_idx  : highest set bit of mask_q
    // Everything here is derived from registers only, so the presented word
    // cannot depend on rd_ready_i.
    // -------------------------------------------------------------------------
    logic [CH_WIDTH-1:0]  sel_idx;
    logic [CH_WIDTH-1:0]  first_idx;
    logic [CH_WIDTH-1:0]  last_idx;
    logic                 sel_found;
    logic [OUT_WIDTH-1:0] sel_data;

    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            if (mask_q[i] && (i >= int'(ptr_q)) && !sel_found) begin
                sel_idx   = CH_WIDTH'(i);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        first_idx = '0;
        for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_idx = CH_WIDTH'(i);
            end
        end
    end

    always_comb begin
        last_idx = '0;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            if (mask_q[i]) begin
                last_idx = CH_WIDTH'(i);
            end
        end
    end

    // Snapshot mux written as a compare loop so the index never runs past the
    // array when CH_WIDTH can address more entries than NUM_FILTERS.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            if (sel_idx == CH_WIDTH'(i)) begin
                sel_data = snap_q[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control terms
    // -------------------------------------------------------------------------
    logic in_scan;
    logic qualify;
    logic handshake;
    logic final_hs;
    logic accept;

    assign in_scan   = (state_q == SCAN);
    assign qualify   = sample_strobe_i & enable_i & (|chan_mask_i);
    assign handshake = valid_q & rd_ready_i;
    assign final_hs  = handshake & (sel_idx == last_idx);
    // A strobe landing on the last transfer of a frame starts the next frame
    // straight away, so there is no idle bubble between frames.
    assign accept    = qualify & (~in_scan | final_hs);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mask_d    = mask_q;
        frame_d   = frame_q;
        ovr_cnt_d = ovr_cnt_q;

        if (final_hs) begin
            frame_d = frame_q + 8'd1;
        end

        if (accept) begin
            state_d = SCAN;
            ptr_d   = '0;
            mask_d  = chan_mask_i;
        end else if (final_hs) begin
            state_d = IDLE;
        end else if (handshake) begin
            ptr_d = sel_idx + CH_WIDTH'(1);
        end

        // A qualifying strobe that cannot start a frame is dropped; the frame
        // in flight keeps its snapshot and mask.
        ovr_d = qualify & in_scan & ~final_hs;
        if (ovr_d && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end

        valid_d = (state_d == SCAN);
    end

    // -------------------------------------------------------------------------
    // Registers (FSM, counters, snapshot)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            mask_q    <= '0;
            frame_q   <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            ovr_cnt_q <= '0;
            for (int i = 0; i < NUM_FILTERS; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            mask_q    <= mask_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            ovr_cnt_q <= ovr_cnt_d;
            if (accept) begin
                for (int i = 0; i < NUM_FILTERS; i++) begin
                    snap_q[i] <= filt_out_i[i*OUT_WIDTH +: OUT_WIDTH];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. The presented-word fields are forced to 0 outside SCAN so the
    // port reads all-zero after reset and between frames.
    // -------------------------------------------------------------------------
    assign rd_valid_o    = valid_q;
    assign rd_data_o     = in_scan ? sel_data : '0;
    assign rd_chan_o     = in_scan ? sel_idx : '0;
    assign rd_first_o    = in_scan & (sel_idx == first_idx);
    assign rd_last_o     = in_scan & (sel_idx == last_idx);
    assign rd_frame_o    = frame_q;
    assign busy_o        = in_scan;
    assign overrun_o     = ovr_q;
    assign overrun_cnt_o = ovr_cnt_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_cic3_row_readout_sched.sv
// -----------------------------------------------------------------------------
// Testbench for cic3_row_readout_sched. A reference model keeps the words of
// the current frame in a queue (built from mask and data at strobe time) plus
// frame and overrun counters; every cycle the DUT port is compared with the
// queue head and counters.
// -----------------------------------------------------------------------------
module tb_cic3_row_readout_sched;

    localparam int NF = 24;
    localparam int OW = 25;
    localparam int CW = 5;
    localparam int WW = CW + OW + 2;          // {chan, data, first, last}
    localparam int VW = 1 + WW + 8 + 1 + 1 + 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          enable;
    logic          sample_strobe;
    logic          rd_ready;
    logic [NF-1:0] chan_mask;
    logic [OW-1:0] filt_arr [NF];
    logic [NF*OW-1:0] filt_out;

    logic [OW-1:0] rd_data;
    logic [CW-1:0] rd_chan;
    logic          rd_valid;
    logic          rd_first;
    logic          rd_last;
    logic [7:0]    rd_frame;
    logic          busy;
    logic          overrun;
    logic [7:0]    overrun_cnt;
    logic          dbg_state;

    for (genvar g = 0; g < NF; g++) begin : g_flat
        assign filt_out[g*OW +: OW] = filt_arr[g];
    end

    cic3_row_readout_sched #(
        .NUM_FILTERS(NF),
        .OUT_WIDTH  (OW),
        .CH_WIDTH   (CW)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .enable_i       (enable),
        .sample_strobe_i(sample_strobe),
        .chan_mask_i    (chan_mask),
        .filt_out_i     (filt_out),
        .rd_data_o      (rd_data),
        .rd_chan_o      (rd_chan),
        .rd_valid_o     (rd_valid),
        .rd_ready_i     (rd_ready),
        .rd_first_o     (rd_first),
        .rd_last_o      (rd_last),
        .rd_frame_o     (rd_frame),
        .busy_o         (busy),
        .overrun_o      (overrun),
        .overrun_cnt_o  (overrun_cnt),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [WW-1:0] exp_q[$];
    int m_frame = 0;
    int m_cnt   = 0;
    bit m_ovr   = 0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Advance the model across the coming clock edge using the inputs just driven.
    task automatic model_update();
        bit hs, fin, qual, acc;
        int lo, hi;
        if (reset) begin
            exp_q.delete();
            m_frame = 0;
            m_cnt   = 0;
            m_ovr   = 0;
            return;
        end
        hs   = (exp_q.size() != 0) && rd_ready;
        fin  = hs && (exp_q.size() == 1);
        qual = sample_strobe && enable && (chan_mask != '0);
        acc  = qual && ((exp_q.size() == 0) || fin);
        if (hs) void'(exp_q.pop_front());
        if (fin) m_frame = (m_frame + 1) % 256;
        m_ovr = qual && !acc;
        if (m_ovr && m_cnt < 255) m_cnt++;
        if (acc) begin
            lo = -1;
            hi = -1;
            for (int i = 0; i < NF; i++) begin
                if (chan_mask[i]) begin
                    if (lo < 0) lo = i;
                    hi = i;
                end
            end
            for (int i = 0; i < NF; i++) begin
                if (chan_mask[i]) begin
                    logic [CW-1:0] ci;
                    logic fb, lb;
                    ci = CW'(i);
                    fb = (i == lo);
                    lb = (i == hi);
                    exp_q.push_back({ci, filt_arr[i], fb, lb});
                end
            end
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [WW-1:0] w;
        logic v;
        v = (exp_q.size() != 0);
        w = v ? exp_q[0] : '0;
        return {v, w, 8'(m_frame), v, m_ovr, 8'(m_cnt)};
    endfunction

    // Word fields are only meaningful while rd_valid is high.
    function automatic logic [VW-1:0] dut_vec();
        logic [CW-1:0] c;
        logic [OW-1:0] d;
        logic f, l;
        c = rd_valid ? rd_chan  : '0;
        d = rd_valid ? rd_data  : '0;
        f = rd_valid ? rd_first : 1'b0;
        l = rd_valid ? rd_last  : 1'b0;
        return {rd_valid, c, d, f, l, rd_frame, busy, overrun, overrun_cnt};
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge: drive inputs, advance the model, wait for the
    // next falling edge where the DUT outputs are sampled.
    task automatic cycle_drive(input logic stb, input logic rdy);
        sample_strobe = stb;
        rd_ready      = rdy;
        model_update();
        @(negedge clk);
        cyc++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cycle_drive(1'b0, 1'b0);
        n_checks++;
        if ({rd_valid, rd_chan, rd_data, rd_first, rd_last, rd_frame, busy, overrun, overrun_cnt, dbg_state} !== '0)
            $display("FAIL reset_outputs cyc=%0d got=%h exp=0", cyc,
                     {rd_valid, rd_chan, rd_data, rd_first, rd_last, rd_frame, busy, overrun, overrun_cnt, dbg_state});
        else n_pass++;
        reset = 1'b0;
        cycle_drive(1'b0, 1'b0);
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_full_frame();
        int words = 0;
        enable    = 1'b1;
        chan_mask = 24'hFFFFFF;
        for (int i = 0; i < NF; i++) filt_arr[i] = OW'(i * 32'h10001);
        repeat (9) cycle_drive(1'b0, 1'b1);
        cycle_drive(1'b1, 1'b1);
        n_checks++;
        if (rd_valid !== 1'b1 || rd_chan !== 5'd0 || rd_first !== 1'b1 || rd_frame !== 8'd0)
            $display("FAIL full_first_word cyc=%0d got v=%b ch=%0d f=%b fr=%0d exp v=1 ch=0 f=1 fr=0", cyc, rd_valid, rd_chan, rd_first, rd_frame);
        else n_pass++;
        for (int k = 0; k < 26; k++) begin
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL full_frame cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            else n_pass++;
            if (rd_valid) words++;
            cycle_drive(1'b0, 1'b1);
        end
        n_checks++;
        if (words !== 24 || rd_frame !== 8'd1)
            $display("FAIL full_word_count words=%0d frame=%0d exp words=24 frame=1", words, rd_frame);
        else n_pass++;
    endtask

    task automatic test_sparse_backpressure();
        logic [3:0] pat = 4'b1001;
        logic [WW+7:0] held = '0;
        bit hold = 0;
        int got_ch[$];
        logic rdy;
        chan_mask = 24'h800101;
        for (int i = 0; i < NF; i++) filt_arr[i] = OW'($urandom);
        cycle_drive(1'b1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            rdy = pat[k % 4];
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL sparse cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            else n_pass++;
            if (hold) begin
                n_checks++;
                if ({rd_chan, rd_data, rd_first, rd_last, rd_frame} !== held)
                    $display("FAIL sparse_hold cyc=%0d got=%h exp=%h", cyc, {rd_chan, rd_data, rd_first, rd_last, rd_frame}, held);
                else n_pass++;
            end
            hold = rd_valid && !rdy;
            held = {rd_chan, rd_data, rd_first, rd_last, rd_frame};
            if (rd_valid && rdy) got_ch.push_back(int'(rd_chan));
            // inputs change mid-frame; the snapshot must not follow them
            for (int i = 0; i < NF; i++) filt_arr[i] = OW'($urandom);
            chan_mask = NF'($urandom);
            cycle_drive(1'b0, rdy);
        end
        n_checks++;
        if (got_ch.size() != 3) $display("FAIL sparse_channels count=%0d exp=3", got_ch.size());
        else if (got_ch[0] != 0 || got_ch[1] != 8 || got_ch[2] != 23)
            $display("FAIL sparse_channels got=%0d,%0d,%0d exp=0,8,23", got_ch[0], got_ch[1], got_ch[2]);
        else n_pass++;
    endtask

    task automatic test_overrun();
        chan_mask = 24'hFFFFFF;
        for (int i = 0; i < NF; i++) filt_arr[i] = OW'($urandom);
        cycle_drive(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL overrun_wait cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            else n_pass++;
            cycle_drive(1'b0, 1'b0);
        end
        for (int i = 0; i < NF; i++) filt_arr[i] = OW'($urandom);
        cycle_drive(1'b1, 1'b0);
        n_checks++;
        if (overrun !== 1'b1 || overrun_cnt !== 8'd1)
            $display("FAIL overrun_first got ovr=%b cnt=%0d exp ovr=1 cnt=1", overrun, overrun_cnt);
        else n_pass++;
        cycle_drive(1'b0, 1'b0);
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL overrun_pulse_end cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
        else n_pass++;
        for (int k = 0; k < 300; k++) cycle_drive(1'b1, 1'b0);
        n_checks++;
        if (overrun_cnt !== 8'd255) $display("FAIL overrun_saturate got=%0d exp=255", overrun_cnt);
        else n_pass++;
        for (int k = 0; k < 28; k++) begin
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL overrun_drain cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            else n_pass++;
            cycle_drive(1'b0, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        bit saw_wrap = 0;
        logic [7:0] prev = 8'd0;
        bit prev_v = 0;
        chan_mask = 24'h000001;
        for (int k = 0; k < 300; k++) begin
            filt_arr[0] = OW'($urandom);
            cycle_drive(1'b1, 1'b1);
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            else n_pass++;
            if (prev_v && rd_valid && prev == 8'd255 && rd_frame == 8'd0) saw_wrap = 1;
            prev   = rd_frame;
            prev_v = rd_valid;
        end
        n_checks++;
        if (saw_wrap !== 1'b1) $display("FAIL back_to_back_wrap got=%0d exp=1", saw_wrap);
        else n_pass++;
        cycle_drive(1'b0, 1'b1);
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL back_to_back_end cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        chan_mask = 24'hFFFFFF;
        for (int i = 0; i < NF; i++) filt_arr[i] = OW'($urandom);
        cycle_drive(1'b1, 1'b1);
        repeat (3) cycle_drive(1'b0, 1'b1);
        reset = 1'b1;
        cycle_drive(1'b0, 1'b1);
        n_checks++;
        if ({rd_valid, rd_chan, rd_data, rd_first, rd_last, rd_frame, busy, overrun, overrun_cnt} !== '0)
            $display("FAIL reset_mid_frame cyc=%0d got=%h exp=0", cyc,
                     {rd_valid, rd_chan, rd_data, rd_first, rd_last, rd_frame, busy, overrun, overrun_cnt});
        else n_pass++;
        reset = 1'b0;
        cycle_drive(1'b1, 1'b1);
        n_checks++;
        if (rd_valid !== 1'b1 || rd_chan !== 5'd0 || rd_frame !== 8'd0 || rd_data !== filt_arr[0])
            $display("FAIL restart_after_reset got v=%b ch=%0d fr=%0d d=%h exp v=1 ch=0 fr=0 d=%h", rd_valid, rd_chan, rd_frame, rd_data, filt_arr[0]);
        else n_pass++;
        for (int k = 0; k < 26; k++) begin
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL restart_drain cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            else n_pass++;
            cycle_drive(1'b0, 1'b1);
        end
    endtask

    task automatic test_disabled_empty();
        logic [7:0] fr0, cnt0;
        fr0  = rd_frame;
        cnt0 = overrun_cnt;
        enable    = 1'b0;
        chan_mask = 24'hFFFFFF;
        cycle_drive(1'b1, 1'b1);
        cycle_drive(1'b0, 1'b1);
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL disabled cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
        else n_pass++;
        enable    = 1'b1;
        chan_mask = '0;
        cycle_drive(1'b1, 1'b1);
        n_checks++;
        if (rd_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0)
            $display("FAIL empty_mask got v=%b ovr=%b busy=%b exp 0 0 0", rd_valid, overrun, busy);
        else n_pass++;
        cycle_drive(1'b0, 1'b1);
        n_checks++;
        if (rd_frame !== fr0 || overrun_cnt !== cnt0)
            $display("FAIL ignored_counters got fr=%0d cnt=%0d exp fr=%0d cnt=%0d", rd_frame, overrun_cnt, fr0, cnt0);
        else n_pass++;
    endtask

    task automatic test_random();
        logic stb, rdy;
        for (int k = 0; k < 2000; k++) begin
            reset  = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 5))
                0:       chan_mask = '0;
                1:       chan_mask = NF'(1) << $urandom_range(0, NF - 1);
                2:       chan_mask = 24'hFFFFFF;
                default: chan_mask = NF'($urandom);
            endcase
            filt_arr[$urandom_range(0, NF - 1)] = OW'($urandom);
            stb = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            cycle_drive(stb, rdy);
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        sample_strobe = 1'b0;
        rd_ready      = 1'b0;
        chan_mask     = '0;
        for (int i = 0; i < NF; i++) filt_arr[i] = '0;
        @(negedge clk);

        test_reset();
        test_full_frame();
        test_sparse_backpressure();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_disabled_empty();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
